// File: rtl/fxp_div_seq_pkg.sv
// ---------------------------------------------------------------------------
// fxp_div_seq_pkg
// Shared definitions for the sequential fixed-point divider:
//   - divider state encoding (LOAD / DIV / FIN / DONE)
//   - default Q-format geometry and its saturation constants
//   - fixed-point <-> real conversion helpers for the default Q format,
//     used by benches to describe operands in real units
// ---------------------------------------------------------------------------
package fxp_div_seq_pkg;

    // Default Q format shared with the matdet stages
    localparam int FXP_DATA_WIDTH = 32;
    localparam int FXP_BIN_POS    = 16;

    // Saturation limits for the default width
    localparam logic [FXP_DATA_WIDTH-1:0] QMAX = {1'b0, {(FXP_DATA_WIDTH-1){1'b1}}};
    localparam logic [FXP_DATA_WIDTH-1:0] QMIN = {1'b1, {(FXP_DATA_WIDTH-1){1'b0}}};

    // Divider control states
    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_DIV  = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } div_state_t;

    // Q value to real number
    function automatic real fxp_to_real(input logic signed [FXP_DATA_WIDTH-1:0] v);
        return real'(v) / (2.0 ** FXP_BIN_POS);
    endfunction

    // Real number to Q value, truncated toward zero
    function automatic logic [FXP_DATA_WIDTH-1:0] fxp_from_real(input real r);
        return FXP_DATA_WIDTH'($rtoi(r * (2.0 ** FXP_BIN_POS)));
    endfunction

endpackage

// File: rtl/fxp_div_seq.sv
// ---------------------------------------------------------------------------
// fxp_div_seq
// Sequential signed fixed-point divider: quot = num / den in Q format
// (DATA_WIDTH bits total, BIN_POS fraction bits, two's complement).
// Restoring division on magnitudes, one quotient bit per clock, MSB first,
// followed by sign application with saturation. Truncates toward zero.
//
// Start/complete handshake: releasing rst starts a division; complete then
// rises and holds until rst is asserted again. rst always wins.
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset / start strobe
//   complete    out  quot and div_by_zero valid, held until rst
//   num         in   signed Q dividend, sampled only in the LOAD cycle
//   den         in   signed Q divisor, sampled only in the LOAD cycle
//   quot        out  signed Q quotient (saturated)
//   div_by_zero out  den was zero; quot is then QMAX/QMIN by sign of num
//
// BIN_POS must be at least 1 and less than DATA_WIDTH.
// ---------------------------------------------------------------------------
module fxp_div_seq
    import fxp_div_seq_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BIN_POS    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  complete,
    input  logic [DATA_WIDTH-1:0] num,
    input  logic [DATA_WIDTH-1:0] den,
    output logic [DATA_WIDTH-1:0] quot,
    output logic                  div_by_zero
);

    // Width of the pre-shifted dividend and of the raw quotient magnitude
    localparam int QW = DATA_WIDTH + BIN_POS;
    localparam int CW = $clog2(QW + 1);

    localparam logic [DATA_WIDTH-1:0] QMAX_L   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] QMIN_L   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONE_W    = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]         CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]         CNT_LAST = CW'(QW - 1);
    // Largest magnitudes representable for each sign, widened to QW bits
    localparam logic [QW-1:0]         POS_LIM  = {{BIN_POS{1'b0}}, QMAX_L};
    localparam logic [QW-1:0]         NEG_LIM  = {{BIN_POS{1'b0}}, QMIN_L};

    div_state_t state_r;
    div_state_t state_nx_s;

    logic                  sign_r;      // result sign
    logic                  num_neg_r;   // dividend sign, picks the dbz limit
    logic                  dbz_r;
    logic [DATA_WIDTH-1:0] den_mag_r;
    logic [QW-1:0]         dividend_r;  // |num| << BIN_POS, shifted out MSB first
    logic [DATA_WIDTH:0]   rem_r;
    logic [CW-1:0]         cnt_r;
    logic [QW-1:0]         quo_r;       // quotient magnitude, shifted in LSB first

    logic [DATA_WIDTH-1:0] num_mag_s;
    logic [DATA_WIDTH-1:0] den_mag_s;
    logic [DATA_WIDTH:0]   trial_s;
    logic [DATA_WIDTH:0]   rem_nx_s;
    logic                  ge_s;
    logic [DATA_WIDTH-1:0] fin_quot_s;

    // Operand magnitudes; the most negative value maps to 2^(DATA_WIDTH-1)
    // which still fits as an unsigned DATA_WIDTH-bit number
    always_comb begin
        num_mag_s = num;
        den_mag_s = den;
        if (num[DATA_WIDTH-1]) begin
            num_mag_s = ~num + ONE_W;
        end else begin
            num_mag_s = num;
        end
        if (den[DATA_WIDTH-1]) begin
            den_mag_s = ~den + ONE_W;
        end else begin
            den_mag_s = den;
        end
    end

    // One restoring-division step: shift in the next dividend bit and
    // subtract the divisor when it fits. The remainder stays below |den|,
    // so the shifted trial value always fits in DATA_WIDTH+1 bits.
    always_comb begin
        trial_s  = (rem_r << 1) | {{DATA_WIDTH{1'b0}}, dividend_r[QW-1]};
        ge_s     = (trial_s >= {1'b0, den_mag_r});
        rem_nx_s = trial_s;
        if (ge_s) begin
            rem_nx_s = trial_s - {1'b0, den_mag_r};
        end else begin
            rem_nx_s = trial_s;
        end
    end

    // Final quotient: divide-by-zero limits, saturation, then sign
    always_comb begin
        fin_quot_s = ZERO_W;
        if (dbz_r) begin
            if (num_neg_r) begin
                fin_quot_s = QMIN_L;
            end else begin
                fin_quot_s = QMAX_L;
            end
        end else if (!sign_r) begin
            if (quo_r > POS_LIM) begin
                fin_quot_s = QMAX_L;
            end else begin
                fin_quot_s = quo_r[DATA_WIDTH-1:0];
            end
        end else begin
            // Magnitude exactly 2^(DATA_WIDTH-1) negates to QMIN itself
            if (quo_r > NEG_LIM) begin
                fin_quot_s = QMIN_L;
            end else begin
                fin_quot_s = ~quo_r[DATA_WIDTH-1:0] + ONE_W;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if (den == ZERO_W) begin
                    state_nx_s = ST_FIN;
                end else begin
                    state_nx_s = ST_DIV;
                end
            end
            ST_DIV: begin
                if (cnt_r == CNT_LAST) begin
                    state_nx_s = ST_FIN;
                end else begin
                    state_nx_s = ST_DIV;
                end
            end
            ST_FIN:  state_nx_s = ST_DONE;
            ST_DONE: state_nx_s = ST_DONE;
            default: state_nx_s = ST_LOAD;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            sign_r      <= 1'b0;
            num_neg_r   <= 1'b0;
            dbz_r       <= 1'b0;
            den_mag_r   <= ZERO_W;
            dividend_r  <= {QW{1'b0}};
            rem_r       <= {(DATA_WIDTH+1){1'b0}};
            cnt_r       <= CNT_ZERO;
            quo_r       <= {QW{1'b0}};
            quot        <= ZERO_W;
            div_by_zero <= 1'b0;
            complete    <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD: begin
                    sign_r     <= num[DATA_WIDTH-1] ^ den[DATA_WIDTH-1];
                    num_neg_r  <= num[DATA_WIDTH-1];
                    dbz_r      <= (den == ZERO_W);
                    den_mag_r  <= den_mag_s;
                    dividend_r <= {num_mag_s, {BIN_POS{1'b0}}};
                    rem_r      <= {(DATA_WIDTH+1){1'b0}};
                    cnt_r      <= CNT_ZERO;
                    quo_r      <= {QW{1'b0}};
                end
                ST_DIV: begin
                    dividend_r <= dividend_r << 1;
                    rem_r      <= rem_nx_s;
                    quo_r      <= {quo_r[QW-2:0], ge_s};
                    cnt_r      <= cnt_r + CNT_ONE;
                end
                ST_FIN: begin
                    quot        <= fin_quot_s;
                    div_by_zero <= dbz_r;
                    complete    <= 1'b1;
                end
                ST_DONE: begin
                    complete <= 1'b1;
                end
                default: begin
                    complete <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_div_seq.sv
// ---------------------------------------------------------------------------
// tb_fxp_div_seq
// Directed and randomised checks of fxp_div_seq (Q16.16 defaults) against a
// reference that divides with 64-bit integer arithmetic and saturates.
// ---------------------------------------------------------------------------
module tb_fxp_div_seq;

    logic        clk;
    logic        rst;
    logic        complete;
    logic [31:0] num;
    logic [31:0] den;
    logic [31:0] quot;
    logic        div_by_zero;

    int tests_run;
    int tests_failed;

    fxp_div_seq #(.DATA_WIDTH(32), .BIN_POS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .complete    (complete),
        .num         (num),
        .den         (den),
        .quot        (quot),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact quotient of the real values, truncated toward zero,
    // clamped to the 32-bit signed range
    function automatic logic [31:0] ref_quot(input logic [31:0] n, input logic [31:0] d);
        longint nn;
        longint dd;
        longint q;
        logic [63:0] qb;
        nn = longint'($signed(n));
        dd = longint'($signed(d));
        if (dd == 0) return (nn >= 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        q = (nn * 65536) / dd;
        if (q > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (q < -64'sd2147483648) return 32'h8000_0000;
        qb = q;
        return qb[31:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Count edges from rst release until complete, then check the result
    task automatic wait_done(input string tag, input logic [31:0] n, input logic [31:0] d,
                             input bit toggle);
        int edges;
        edges = 0;
        rst = 1'b0;
        while (complete !== 1'b1 && edges < 200) begin
            @(posedge clk);
            #1;
            edges++;
            if (toggle && edges >= 3) begin
                num = $urandom;
                den = $urandom;
            end
        end
        chk({tag, " latency"}, 64'(edges), (d == 32'h0) ? 64'd2 : 64'd50);
        chk({tag, " quot"}, 64'(quot), 64'(ref_quot(n, d)));
        chk({tag, " dbz"}, 64'(div_by_zero), (d == 32'h0) ? 64'd1 : 64'd0);
    endtask

    task automatic run_div(input string tag, input logic [31:0] n, input logic [31:0] d);
        rst = 1'b1;
        num = n;
        den = d;
        @(posedge clk);
        #1;
        chk({tag, " rst complete"}, 64'(complete), 64'd0);
        wait_done(tag, n, d, 1'b0);
    endtask

    initial begin
        logic [31:0] rn;
        logic [31:0] rd;
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        num = 32'h0;
        den = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset complete", 64'(complete), 64'd0);
        chk("reset quot", 64'(quot), 64'd0);
        chk("reset dbz", 64'(div_by_zero), 64'd0);

        // Directed values, also cross-checked against spelled-out constants
        run_div("pos 3/2", 32'h0003_0000, 32'h0002_0000);
        chk("pos 3/2 const", 64'(quot), 64'h0001_8000);
        run_div("neg -1/3", 32'hFFFF_0000, 32'h0003_0000);
        chk("neg -1/3 const", 64'(quot), 64'hFFFF_AAAB);
        run_div("dbz pos", 32'h0005_0000, 32'h0000_0000);
        chk("dbz pos const", 64'(quot), 64'h7FFF_FFFF);
        run_div("dbz neg", 32'hFFFB_0000, 32'h0000_0000);
        chk("dbz neg const", 64'(quot), 64'h8000_0000);
        run_div("sat pos", 32'h7FFF_0000, 32'h0000_8000);
        chk("sat pos const", 64'(quot), 64'h7FFF_FFFF);
        run_div("sat neg", 32'h7FFF_0000, 32'hFFFF_8000);
        chk("sat neg const", 64'(quot), 64'h8000_0000);
        run_div("zero num", 32'h0000_0000, 32'hFFFD_0000);
        chk("zero num const", 64'(quot), 64'h0);
        run_div("minneg/1", 32'h8000_0000, 32'h0001_0000);
        chk("minneg/1 const", 64'(quot), 64'h8000_0000);
        run_div("minneg/-1", 32'h8000_0000, 32'hFFFF_0000);
        chk("minneg/-1 const", 64'(quot), 64'h7FFF_FFFF);
        run_div("frac", 32'h0001_8000, 32'hFFFE_4000);

        // rst after complete: rst wins on the very next edge
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst over complete", 64'(complete), 64'd0);

        // Reset mid-division, then restart with new operands
        num = 32'h0003_0000;
        den = 32'h0002_0000;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        num = 32'h0001_0000;
        den = 32'h0004_0000;
        @(posedge clk);
        #1;
        chk("midrst complete", 64'(complete), 64'd0);
        chk("midrst quot", 64'(quot), 64'd0);
        wait_done("restart 1/4", 32'h0001_0000, 32'h0004_0000, 1'b0);
        chk("restart 1/4 const", 64'(quot), 64'h0000_4000);

        // Operands changing during DIV must not affect the result
        rst = 1'b1;
        num = 32'h0003_0000;
        den = 32'h0002_0000;
        @(posedge clk);
        #1;
        wait_done("toggle", 32'h0003_0000, 32'h0002_0000, 1'b1);

        // Randomised regression: integer part -9..9 plus a random fraction
        for (int i = 0; i < 60; i++) begin
            rn = ((32'($urandom_range(18)) - 32'd9) << 16) + 32'($urandom_range(16'hFFFF));
            rd = ((32'($urandom_range(18)) - 32'd9) << 16) + 32'($urandom_range(16'hFFFF));
            if ((i % 10) == 3) rd = 32'h0;
            if ((i % 10) == 7) rd = 32'($urandom_range(16'h00FF));
            run_div($sformatf("rand%0d", i), rn, rd);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
